// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates one single-ported memory between instruction fetch
// and data access using a req/ack handshake and an IDLE/ACC_I/ACC_D sequencer.
// Optional feature macro: MEM_ARB_PERF_EN adds saturating wait-cycle counters.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request (held until if_ack), PC
//   if_ack/if_inst            1-cycle ack pulse, registered instruction
//   halt                      blocks new fetch grants (sampled at grant only)
//   d_req/d_we/d_funct3       data request, store flag, size/sign
//   d_addr/d_wdata            data address and store data
//   d_ack/d_rdata             1-cycle ack pulse, registered load data
//   perf_if_wait/perf_d_wait  wait-cycle counters (MEM_ARB_PERF_EN only)
//   mem_rd/mem_wr/mem_funct3  memory strobes and size/sign
//   mem_addr/mem_wdata        memory address and write data
//   mem_rdata                 memory read data, valid in last access cycle
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned MAX_DATA_RUN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_inst,
    input  logic        halt,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0] perf_if_wait,
    output logic [31:0] perf_d_wait,
`endif
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned LAT_W = 3;
    localparam int unsigned RUN_W = (MAX_DATA_RUN < 2) ? 1 : $clog2(MAX_DATA_RUN + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);
    localparam logic [2:0]       F3_WORD  = 3'b010;

    typedef enum logic [1:0] {IDLE, ACC_I, ACC_D} state_e;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               if_ack_q, if_ack_d;
    logic               d_ack_q, d_ack_d;
    logic [31:0]        if_inst_q, if_inst_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic [2:0]         mem_funct3_q, mem_funct3_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic d_elig_c, i_elig_c, run_full_c, grant_d_c, grant_i_c;

    // Grant decision; a requester is not eligible in the cycle its ack is showing.
    always_comb begin
        d_elig_c   = d_req & ~d_ack_q;
        i_elig_c   = if_req & ~if_ack_q & ~halt;
        run_full_c = (MAX_DATA_RUN != 0) && (run_q == RUN_MAX);
        grant_d_c  = (state_q == IDLE) & d_elig_c & ~(i_elig_c & run_full_c);
        grant_i_c  = (state_q == IDLE) & i_elig_c & (~d_elig_c | run_full_c);
    end

    // Next-state, memory-port latch and ack/data capture.
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_inst_d    = if_inst_q;
        d_rdata_d    = d_rdata_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        mem_funct3_d = mem_funct3_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d_c) begin
                    state_d      = ACC_D;
                    lat_d        = LAT_INIT;
                    mem_rd_d     = ~d_we;
                    mem_wr_d     = d_we;
                    mem_funct3_d = d_funct3;
                    mem_addr_d   = d_addr;
                    mem_wdata_d  = d_wdata;
                end else if (grant_i_c) begin
                    state_d      = ACC_I;
                    lat_d        = LAT_INIT;
                    mem_rd_d     = 1'b1;
                    mem_wr_d     = 1'b0;
                    mem_funct3_d = F3_WORD;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = 32'h0;
                end
            end
            ACC_I, ACC_D: begin
                if (lat_q == '0) begin
                    // Last access cycle: capture, ack next cycle, release the port.
                    if (state_q == ACC_I) begin
                        if_inst_d = mem_rdata;
                        if_ack_d  = 1'b1;
                    end else begin
                        if (!mem_wr_q) d_rdata_d = mem_rdata;
                        d_ack_d = 1'b1;
                    end
                    state_d      = IDLE;
                    mem_rd_d     = 1'b0;
                    mem_wr_d     = 1'b0;
                    mem_funct3_d = 3'b000;
                    mem_addr_d   = 32'h0;
                    mem_wdata_d  = 32'h0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Consecutive data grants while fetch waits; saturates at the limit.
    always_comb begin
        run_d = run_q;
        if (!if_req || grant_i_c) begin
            run_d = '0;
        end else if (grant_d_c && (run_q != RUN_MAX)) begin
            run_d = run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            run_q        <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_inst_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_funct3_q <= 3'b000;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            run_q        <= run_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_inst_q    <= if_inst_d;
            d_rdata_q    <= d_rdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_funct3_q <= mem_funct3_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_d_q, perf_d_d;

    // Saturating count of cycles each requester waits without an ack.
    always_comb begin
        perf_if_d = perf_if_q;
        perf_d_d  = perf_d_q;
        if (if_req && !if_ack_q && (perf_if_q != 32'hFFFF_FFFF)) perf_if_d = perf_if_q + 32'd1;
        if (d_req && !d_ack_q && (perf_d_q != 32'hFFFF_FFFF))    perf_d_d  = perf_d_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_q <= 32'h0;
            perf_d_q  <= 32'h0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_d_q  <= perf_d_d;
        end
    end

    assign perf_if_wait = perf_if_q;
    assign perf_d_wait  = perf_d_q;
`endif

    assign if_ack     = if_ack_q;
    assign d_ack      = d_ack_q;
    assign if_inst    = if_inst_q;
    assign d_rdata    = d_rdata_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_funct3 = mem_funct3_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a uses MEM_LAT=1, instance b MEM_LAT=3.
// Both share request inputs; each check targets the instance its scenario is written for.
// Memory model: address 0x10 returns 0x00500093, any other address returns addr+0x1000_0000.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        halt;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        a_if_ack, a_d_ack, a_mem_rd, a_mem_wr;
    logic [31:0] a_if_inst, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [2:0]  a_mem_funct3;
    logic        b_if_ack, b_d_ack, b_mem_rd, b_mem_wr;
    logic [31:0] b_if_inst, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [2:0]  b_mem_funct3;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] a_perf_if, a_perf_d, b_perf_if, b_perf_d;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign a_mem_rdata = (a_mem_addr == 32'h10) ? 32'h0050_0093 : (a_mem_addr + 32'h1000_0000);
    assign b_mem_rdata = (b_mem_addr == 32'h10) ? 32'h0050_0093 : (b_mem_addr + 32'h1000_0000);

    mem_port_arbiter #(.MEM_LAT(1), .MAX_DATA_RUN(2)) u_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(a_if_ack), .if_inst(a_if_inst),
        .halt(halt),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(a_d_ack), .d_rdata(a_d_rdata),
`ifdef MEM_ARB_PERF_EN
        .perf_if_wait(a_perf_if), .perf_d_wait(a_perf_d),
`endif
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_funct3(a_mem_funct3),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(3), .MAX_DATA_RUN(2)) u_b (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(b_if_ack), .if_inst(b_if_inst),
        .halt(halt),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
`ifdef MEM_ARB_PERF_EN
        .perf_if_wait(b_perf_if), .perf_d_wait(b_perf_d),
`endif
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_funct3(b_mem_funct3),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; halt = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk1("rst_if_ack", a_if_ack, 1'b0);
        chk1("rst_d_ack", a_d_ack, 1'b0);
        chk1("rst_mem_rd", a_mem_rd, 1'b0);
        chk1("rst_mem_wr", a_mem_wr, 1'b0);
        chk("rst_mem_addr", a_mem_addr, 32'h0);
        chk("rst_mem_f3", 32'(a_mem_funct3), 32'h0);
        chk("rst_mem_wdata", a_mem_wdata, 32'h0);
        chk("rst_if_inst", a_if_inst, 32'h0);
        chk("rst_d_rdata", a_d_rdata, 32'h0);
`ifdef MEM_ARB_PERF_EN
        chk("rst_perf_if", a_perf_if, 32'h0);
        chk("rst_perf_d", a_perf_d, 32'h0);
`endif

        // Fetch only, MEM_LAT=1
        if_req = 1'b1; if_addr = 32'h10;
        step();
        chk1("f1_mem_rd", a_mem_rd, 1'b1);
        chk1("f1_mem_wr", a_mem_wr, 1'b0);
        chk("f1_mem_addr", a_mem_addr, 32'h10);
        chk("f1_mem_f3", 32'(a_mem_funct3), 32'h2);
        chk1("f1_no_early_ack", a_if_ack, 1'b0);
        step();
        chk1("f1_if_ack", a_if_ack, 1'b1);
        chk("f1_if_inst", a_if_inst, 32'h0050_0093);
        chk1("f1_mem_rd_off", a_mem_rd, 1'b0);
        chk("f1_mem_addr_off", a_mem_addr, 32'h0);
        if_req = 1'b0;
        step();
        chk1("f1_ack_pulse", a_if_ack, 1'b0);

        // Simultaneous fetch and lw: data first, fetch granted in the d_ack cycle
        if_req = 1'b1; if_addr = 32'h14;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h40;
        step();
        chk("both_d_addr", a_mem_addr, 32'h40);
        chk1("both_d_rd", a_mem_rd, 1'b1);
        chk1("both_d_wr", a_mem_wr, 1'b0);
        step();
        chk1("both_d_ack", a_d_ack, 1'b1);
        chk("both_d_rdata", a_d_rdata, 32'h1000_0040);
        chk1("both_if_wait", a_if_ack, 1'b0);
        d_req = 1'b0;
        step();
        chk("both_i_addr", a_mem_addr, 32'h14);
        chk1("both_i_rd", a_mem_rd, 1'b1);
        chk1("both_d_ack_pulse", a_d_ack, 1'b0);
        step();
        chk1("both_if_ack", a_if_ack, 1'b1);
        chk("both_if_inst", a_if_inst, 32'h1000_0014);
        if_req = 1'b0;
        step();

        // Both held continuously: each ack cycle hands the port to the other side
        d_req = 1'b1; d_addr = 32'h80; if_req = 1'b1; if_addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("alt_grant_addr", a_mem_addr, (k % 2 == 0) ? 32'h80 : 32'h20);
            step();
            if (k % 2 == 0) begin
                chk1("alt_d_ack", a_d_ack, 1'b1);
                chk("alt_d_rdata", a_d_rdata, 32'h1000_0080);
            end else begin
                chk1("alt_if_ack", a_if_ack, 1'b1);
                chk("alt_if_inst", a_if_inst, 32'h1000_0020);
            end
            if (k == 3) begin
                d_req = 1'b0; if_req = 1'b0;
            end
        end
        step();

        // Halt: only data served; run reaches MAX_DATA_RUN so fetch wins on release
        halt = 1'b1; if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_addr = 32'h90;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("halt_d_addr", a_mem_addr, 32'h90);
            chk1("halt_no_if_ack", a_if_ack, 1'b0);
            step();
            chk1("halt_d_ack", a_d_ack, 1'b1);
            chk1("halt_no_if_ack2", a_if_ack, 1'b0);
            step();
            chk1("halt_idle_rd", a_mem_rd, 1'b0);
            chk1("halt_no_if_ack3", a_if_ack, 1'b0);
        end
        halt = 1'b0;
        step();
        chk("rel_i_addr", a_mem_addr, 32'h30);
        chk1("rel_i_rd", a_mem_rd, 1'b1);
        chk1("rel_i_wr", a_mem_wr, 1'b0);
        step();
        chk1("rel_if_ack", a_if_ack, 1'b1);
        chk("rel_if_inst", a_if_inst, 32'h1000_0030);
        chk1("rel_no_d_ack", a_d_ack, 1'b0);
        if_req = 1'b0; d_req = 1'b0;

        // MEM_LAT=3 instance: load then sb store
        rst = 1'b1;
        step();
        rst = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h44;
        step();
        chk1("l3_rd_c1", b_mem_rd, 1'b1);
        chk("l3_addr_c1", b_mem_addr, 32'h44);
        step();
        chk1("l3_rd_c2", b_mem_rd, 1'b1);
        step();
        chk1("l3_rd_c3", b_mem_rd, 1'b1);
        chk1("l3_no_ack_c3", b_d_ack, 1'b0);
        step();
        chk1("l3_d_ack", b_d_ack, 1'b1);
        chk("l3_d_rdata", b_d_rdata, 32'h1000_0044);
        chk1("l3_rd_off", b_mem_rd, 1'b0);
        d_req = 1'b0;
        step();
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b000; d_addr = 32'h23; d_wdata = 32'hAB;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("sb_wr", b_mem_wr, 1'b1);
            chk1("sb_rd", b_mem_rd, 1'b0);
            chk("sb_f3", 32'(b_mem_funct3), 32'h0);
            chk("sb_addr", b_mem_addr, 32'h23);
            chk("sb_wdata", b_mem_wdata, 32'hAB);
            chk1("sb_no_ack", b_d_ack, 1'b0);
        end
        step();
        chk1("sb_d_ack", b_d_ack, 1'b1);
        chk("sb_rdata_held", b_d_rdata, 32'h1000_0044);
        chk1("sb_wr_off", b_mem_wr, 1'b0);
        d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
        step();

        // Reset in the middle of a MEM_LAT=3 fetch aborts it without ack
        if_req = 1'b1; if_addr = 32'h50;
        step();
        chk1("ra_rd_c1", b_mem_rd, 1'b1);
        chk("ra_addr_c1", b_mem_addr, 32'h50);
        step();
        chk1("ra_rd_c2", b_mem_rd, 1'b1);
        rst = 1'b1;
        step();
        chk1("ra_rd_off", b_mem_rd, 1'b0);
        chk("ra_addr_off", b_mem_addr, 32'h0);
        chk1("ra_no_ack", b_if_ack, 1'b0);
`ifdef MEM_ARB_PERF_EN
        chk("ra_perf_if", b_perf_if, 32'h0);
        chk("ra_perf_d", b_perf_d, 32'h0);
`endif
        rst = 1'b0; if_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk1("ra_no_late_ack", b_if_ack, 1'b0);
            chk1("ra_idle_rd", b_mem_rd, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
